ift_mux_pipe: RTL

IFT_MUX_PIPE -- requirements
Module: ift_mux_pipe

---
 rtl/ift_pkg.sv | 26 ++
 rtl/ift_skid_buf.sv | 89 ++++++++
 rtl/ift_mux_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ift_pkg.sv
// Shared definitions for the information-flow-tracking mux pipeline.
// Holds the default tag width, the tag type, the select-tag rule constants,
// the skid-buffer occupancy encoding and a select-width helper.
package ift_pkg;

    localparam int unsigned TAG_W_DEF = 32;

    typedef logic [TAG_W_DEF-1:0] tag_t;

    // Select-tag propagation rules
    localparam int unsigned PRECISE_CONSERVATIVE = 0;
    localparam int unsigned PRECISE_EXACT        = 1;

    // Skid buffer occupancy
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Select port width: at least one bit even for degenerate channel counts
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ift_skid_buf.sv
// Two-entry in-order skid buffer with valid/ready on both sides.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     upstream handshake; in_ready decoded from registered occupancy
//   in_data [WIDTH]       upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data [WIDTH]      oldest buffered payload, held while stalled
module ift_skid_buf
    import ift_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    occ_t             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             push, pop;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // Next occupancy and entry contents; head is always the oldest beat
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = in_data;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    tail_d = in_data;
                    occ_d  = OCC_FULL;
                end else if (pop) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // in_ready is low here, so only a pop can happen
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        in_ready_d  = (occ_d != OCC_FULL);
        out_valid_d = (occ_d != OCC_EMPTY);
    end

    // State and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q       <= OCC_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_q;

endmodule

// File: rtl/ift_mux_pipe.sv
// Taint-tracking N-way mux with a registered two-entry output stage.
// Each accepted beat carries the selected channel and a tag combining the
// channel tag with the select tag; tainted output transfers are counted.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake
//   in_data [N_IN*DATA_W]      packed data channels, channel k at [k*DATA_W +: DATA_W]
//   in_tag  [N_IN*TAG_W]       packed channel tags, tag k at [k*TAG_W +: TAG_W]
//   sel [SEL_W], sel_tag       channel select and its taint tag
//   out_valid/out_ready        output handshake
//   out_data, out_tag          selected data and propagated tag
//   taint_cnt, taint_sticky    saturating tainted-transfer count and sticky flag
//   clr                        synchronous clear of the taint counters
module ift_mux_pipe
    import ift_pkg::*;
#(
    parameter  int unsigned N_IN    = 2,
    parameter  int unsigned DATA_W  = 1,
    parameter  int unsigned TAG_W   = TAG_W_DEF,
    parameter  int unsigned PRECISE = PRECISE_EXACT,
    parameter  int unsigned CNT_W   = 16,
    localparam int unsigned SEL_W   = sel_width(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [N_IN*TAG_W-1:0]  in_tag,
    input  logic [SEL_W-1:0]       sel,
    input  logic [TAG_W-1:0]       sel_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [CNT_W-1:0]       taint_cnt,
    output logic                   taint_sticky,
    input  logic                   clr
);

    localparam int unsigned BEAT_W = DATA_W + TAG_W;

    logic [DATA_W-1:0] mux_data;
    logic [TAG_W-1:0]  base_tag;
    logic [TAG_W-1:0]  beat_tag;
    logic              sel_hit;
    logic              all_eq;
    logic [BEAT_W-1:0] buf_out;

    // Channel mux, equality detect and select-tag rule
    always_comb begin
        mux_data = '0;
        base_tag = '0;
        sel_hit  = 1'b0;
        all_eq   = 1'b1;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (32'(sel) == k) begin
                mux_data = in_data[k*DATA_W +: DATA_W];
                base_tag = in_tag[k*TAG_W +: TAG_W];
                sel_hit  = 1'b1;
            end
            if (in_data[k*DATA_W +: DATA_W] != in_data[0 +: DATA_W]) begin
                all_eq = 1'b0;
            end
        end
        // Out-of-range select yields zero data; only the select tag explains it
        if (!sel_hit) begin
            beat_tag = sel_tag;
        end else if (PRECISE == PRECISE_CONSERVATIVE || !all_eq) begin
            beat_tag = base_tag | sel_tag;
        end else begin
            // All channels equal: the select cannot influence the data
            beat_tag = base_tag;
        end
    end

    ift_skid_buf #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({mux_data, beat_tag}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign out_data = buf_out[BEAT_W-1:TAG_W];
    assign out_tag  = buf_out[TAG_W-1:0];

    logic             tainted_xfer;
    logic [CNT_W-1:0] cnt_d;
    logic             sticky_d;

    assign tainted_xfer = out_valid && out_ready && (out_tag != '0);

    // Taint counter next state; a coincident clear still records the current transfer
    always_comb begin
        cnt_d    = taint_cnt;
        sticky_d = taint_sticky;
        if (clr) begin
            cnt_d    = tainted_xfer ? CNT_W'(1) : '0;
            sticky_d = tainted_xfer;
        end else if (tainted_xfer) begin
            sticky_d = 1'b1;
            if (taint_cnt != {CNT_W{1'b1}}) begin
                cnt_d = taint_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taint_cnt    <= '0;
            taint_sticky <= 1'b0;
        end else begin
            taint_cnt    <= cnt_d;
            taint_sticky <= sticky_d;
        end
    end

endmodule
